// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - Q6.11 fixed-point types, saturation limits and readout FSM states
package lstm_pkg;

    localparam int QN       = 6;
    localparam int QM       = 11;
    localparam int BITWIDTH = QN + QM + 1;

    typedef logic signed [BITWIDTH-1:0] fix_t;

    localparam fix_t FIX_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam fix_t FIX_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_MAC,
        ST_FINISH
    } readout_state_t;

endpackage

// File: rtl/dense_readout_mac_lane.sv
// rtl/dense_readout_mac_lane.sv - one readout output: accumulate W*h, then bias/shift/saturate
// Rounding in the final stage is enabled by DENSE_READOUT_ROUND_EN.
import lstm_pkg::*;

module mac_lane #(
    parameter int ACC_BITWIDTH = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    input  logic i_finish,
    input  fix_t i_weight,
    input  fix_t i_hidden,
    input  fix_t i_bias,
    output fix_t o_result
);

    localparam int EXT_BITS = ACC_BITWIDTH - 2*BITWIDTH;

    logic signed [2*BITWIDTH-1:0]   w_mul;
    logic signed [ACC_BITWIDTH-1:0] w_prod;
    logic signed [ACC_BITWIDTH-1:0] w_bias_sh;
    logic signed [ACC_BITWIDTH-1:0] w_sum;
    logic signed [ACC_BITWIDTH-1:0] w_shift;
    logic [ACC_BITWIDTH-BITWIDTH:0] w_upper;
    fix_t                           w_sat;
    logic signed [ACC_BITWIDTH-1:0] r_acc;
    fix_t                           r_result;

    assign w_mul     = i_weight * i_hidden;
    assign w_prod    = {{EXT_BITS{w_mul[2*BITWIDTH-1]}}, w_mul};
    assign w_bias_sh = {{(ACC_BITWIDTH-BITWIDTH){i_bias[BITWIDTH-1]}}, i_bias} <<< QM;

`ifdef DENSE_READOUT_ROUND_EN
    localparam logic signed [ACC_BITWIDTH-1:0] ROUND_HALF = ACC_BITWIDTH'(1) << (QM-1);
    assign w_sum = r_acc + w_bias_sh + ROUND_HALF;
`else
    assign w_sum = r_acc + w_bias_sh;
`endif

    assign w_shift = w_sum >>> QM;
    assign w_upper = w_shift[ACC_BITWIDTH-1:BITWIDTH-1];

    // In range only when every bit above the result's sign bit repeats the sign.
    always_comb begin
        w_sat = w_shift[BITWIDTH-1:0];
        if (!((&w_upper) || !(|w_upper))) begin
            w_sat = w_shift[ACC_BITWIDTH-1] ? FIX_MIN : FIX_MAX;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= r_acc + w_prod;
            end
            if (i_finish) begin
                r_result <= w_sat;
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/dense_readout.sv
// rtl/dense_readout.sv - fully-connected readout y = Wy*h + by after the LSTM network block
// Optional round-half-up in the output stage via DENSE_READOUT_ROUND_EN.
import lstm_pkg::*;

module dense_readout #(
    parameter  int HIDDEN_SZ     = 8,
    parameter  int OUTPUT_SZ     = 1,
    localparam int ADDR_BITWIDTH = $clog2(HIDDEN_SZ),
    localparam int ACC_BITWIDTH  = 2*BITWIDTH + ADDR_BITWIDTH + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [BITWIDTH*HIDDEN_SZ-1:0]   hiddenVec,
    input  logic                            hiddenValid,
    input  logic                            wrEn,
    input  logic                            wrBias,
    input  logic [ADDR_BITWIDTH-1:0]        wrAddr,
    input  logic [BITWIDTH*OUTPUT_SZ-1:0]   wrData,
    output logic [BITWIDTH*OUTPUT_SZ-1:0]   outputVec,
    output logic                            outputValid,
    output logic                            busy,
    output logic                            overrun
);

    localparam logic [ADDR_BITWIDTH-1:0] CNT_LAST = ADDR_BITWIDTH'(HIDDEN_SZ-1);

    readout_state_t                   r_state;
    readout_state_t                   w_next_state;
    logic [ADDR_BITWIDTH-1:0]         r_cnt;
    logic                             r_out_valid;
    logic                             r_overrun;
    fix_t                             r_hidden [HIDDEN_SZ];
    logic [BITWIDTH*OUTPUT_SZ-1:0]    r_weight [HIDDEN_SZ];
    logic [BITWIDTH*OUTPUT_SZ-1:0]    r_bias;

    logic                             r_pend_valid;
    logic                             r_pend_bias;
    logic [ADDR_BITWIDTH-1:0]         r_pend_addr;
    logic [BITWIDTH*OUTPUT_SZ-1:0]    r_pend_data;

    logic                             w_idle;
    logic                             w_direct_wr;
    logic                             w_defer_wr;
    logic                             w_mem_we;
    logic                             w_mem_bias;
    logic [ADDR_BITWIDTH-1:0]         w_mem_addr;
    logic [BITWIDTH*OUTPUT_SZ-1:0]    w_mem_data;
    logic [BITWIDTH*OUTPUT_SZ-1:0]    w_col;
    fix_t                             w_hid;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_direct_wr = w_idle && wrEn && !hiddenValid;
    // A write colliding with a start is parked and committed once the run has read the old value.
    assign w_defer_wr  = w_idle && wrEn && hiddenValid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:   if (hiddenValid) w_next_state = ST_LATCH;
            ST_LATCH:  w_next_state = ST_MAC;
            ST_MAC:    if (r_cnt == CNT_LAST) w_next_state = ST_FINISH;
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_overrun    <= 1'b0;
            r_pend_valid <= 1'b0;
        end else begin
            r_out_valid <= (r_state == ST_FINISH);
            if (hiddenValid && !w_idle) begin
                r_overrun <= 1'b1;
            end
            if (r_state == ST_LATCH) begin
                r_cnt <= '0;
            end else if (r_state == ST_MAC) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_defer_wr) begin
                r_pend_valid <= 1'b1;
            end else if (r_state == ST_FINISH) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_idle && hiddenValid) begin
            for (int j = 0; j < HIDDEN_SZ; j++) begin
                r_hidden[j] <= hiddenVec[j*BITWIDTH +: BITWIDTH];
            end
        end
        if (w_defer_wr) begin
            r_pend_bias <= wrBias;
            r_pend_addr <= wrAddr;
            r_pend_data <= wrData;
        end
    end

    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_bias = wrBias;
        w_mem_addr = wrAddr;
        w_mem_data = wrData;
        if (w_direct_wr) begin
            w_mem_we = 1'b1;
        end else if (r_pend_valid && r_state == ST_FINISH) begin
            w_mem_we   = 1'b1;
            w_mem_bias = r_pend_bias;
            w_mem_addr = r_pend_addr;
            w_mem_data = r_pend_data;
        end
    end

    // Coefficient storage has no reset so loaded weights survive a reset.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            if (w_mem_bias) begin
                r_bias <= w_mem_data;
            end else begin
                r_weight[w_mem_addr] <= w_mem_data;
            end
        end
    end

    assign w_col = r_weight[r_cnt];
    assign w_hid = r_hidden[r_cnt];

    for (genvar k = 0; k < OUTPUT_SZ; k++) begin : g_lane
        fix_t w_lane_w;
        fix_t w_lane_b;
        fix_t w_lane_out;

        assign w_lane_w = w_col[k*BITWIDTH +: BITWIDTH];
        assign w_lane_b = r_bias[k*BITWIDTH +: BITWIDTH];

        mac_lane #(
            .ACC_BITWIDTH (ACC_BITWIDTH)
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .i_clear  (r_state == ST_LATCH),
            .i_en     (r_state == ST_MAC),
            .i_finish (r_state == ST_FINISH),
            .i_weight (w_lane_w),
            .i_hidden (w_hid),
            .i_bias   (w_lane_b),
            .o_result (w_lane_out)
        );

        assign outputVec[k*BITWIDTH +: BITWIDTH] = w_lane_out;
    end

    assign outputValid = r_out_valid;
    assign busy        = !w_idle;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_dense_readout.sv
// tb/tb_dense_readout.sv - directed and randomized checks of dense_readout against an arithmetic model
module tb_dense_readout;

    localparam int H  = 8;
    localparam int O  = 2;
    localparam int BW = 18;
    localparam int AW = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [H*BW-1:0]   hiddenVec;
    logic              hiddenValid;
    logic              wrEn;
    logic              wrBias;
    logic [AW-1:0]     wrAddr;
    logic [O*BW-1:0]   wrData;
    logic [O*BW-1:0]   outputVec;
    logic              outputValid;
    logic              busy;
    logic              overrun;

    int W [O][H];
    int B [O];
    int hv_int [H];
    int n_checks = 0;
    int n_errors = 0;

    dense_readout #(
        .HIDDEN_SZ (H),
        .OUTPUT_SZ (O)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hiddenVec   (hiddenVec),
        .hiddenValid (hiddenValid),
        .wrEn        (wrEn),
        .wrBias      (wrBias),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .outputVec   (outputVec),
        .outputValid (outputValid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] lane(input int k);
        return outputVec[k*BW +: BW];
    endfunction

    function automatic logic [H*BW-1:0] pack_h();
        logic [H*BW-1:0] v;
        for (int j = 0; j < H; j++) v[j*BW +: BW] = BW'(hv_int[j]);
        return v;
    endfunction

    // y = floor((sum W*h + bias*2^11 [+ 2^10]) / 2^11), clamped to the 18-bit signed range.
    function automatic logic [BW-1:0] model(input int k);
        longint s;
        longint r;
        s = 0;
        for (int j = 0; j < H; j++) s += longint'(W[k][j]) * longint'(hv_int[j]);
        s += longint'(B[k]) * 2048;
`ifdef DENSE_READOUT_ROUND_EN
        s += 1024;
`endif
        r = s >>> 11;
        if (r > 131071) r = 131071;
        if (r < -131072) r = -131072;
        return BW'(r);
    endfunction

    task automatic write_word(input logic bias, input int addr, input logic [O*BW-1:0] data);
        wrEn = 1'b1; wrBias = bias; wrAddr = AW'(addr); wrData = data;
        @(posedge clock); #1;
        wrEn = 1'b0;
    endtask

    task automatic load_all();
        logic [O*BW-1:0] d;
        for (int j = 0; j < H; j++) begin
            for (int k = 0; k < O; k++) d[k*BW +: BW] = BW'(W[k][j]);
            write_word(1'b0, j, d);
        end
        for (int k = 0; k < O; k++) d[k*BW +: BW] = BW'(B[k]);
        write_word(1'b1, 0, d);
    endtask

    task automatic fill(input int wv, input int hv, input int bv);
        for (int k = 0; k < O; k++) begin
            B[k] = bv;
            for (int j = 0; j < H; j++) W[k][j] = wv;
        end
        for (int j = 0; j < H; j++) hv_int[j] = hv;
    endtask

    // Starts a run; extra cycles past the nominal pulse confirm there is no second pulse.
    task automatic run(input int hv_again, input int wr_at, input int rst_at, input int extra,
                       output int lat, output int n_valid, output bit busy_ok);
        hiddenVec = pack_h(); hiddenValid = 1'b1;
        @(posedge clock); #1;
        hiddenValid = 1'b0;
        hiddenVec = {$urandom, $urandom, $urandom, $urandom, $urandom};
        lat = -1; n_valid = 0; busy_ok = 1'b1;
        for (int c = 1; c <= 10 + extra; c++) begin
            if (c <= 10 && rst_at < 0 && busy !== 1'b1) busy_ok = 1'b0;
            hiddenValid = (c == hv_again);
            wrEn = (c == wr_at); wrBias = 1'b0; wrAddr = '0; wrData = {$urandom, $urandom};
            if (c == rst_at) reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0; hiddenValid = 1'b0; wrEn = 1'b0;
            if (outputValid === 1'b1) begin
                n_valid++;
                if (lat < 0) lat = c;
            end
        end
    endtask

    task automatic check_lanes(input string tag);
        for (int k = 0; k < O; k++) check($sformatf("%s_lane%0d", tag, k), lane(k), model(k));
    endtask

    initial begin
        int lat, nv;
        bit bok;
        logic [O*BW-1:0] d;

        reset = 1'b1; hiddenVec = '0; hiddenValid = 1'b0;
        wrEn = 1'b0; wrBias = 1'b0; wrAddr = '0; wrData = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_outputVec", outputVec, 0);
        check("rst_outputValid", outputValid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

        fill(2048, 1024, 0);
        load_all();
        run(-1, -1, -1, 2, lat, nv, bok);
        check("basic_latency", lat, 10);
        check("basic_busy", bok, 1);
        check("basic_npulse", nv, 1);
        check("basic_value", lane(0), 8192);
        check_lanes("basic");
        check("basic_busy_after", busy, 0);

        fill(63488, 63488, 0);
        load_all();
        run(-1, -1, -1, 0, lat, nv, bok);
        check("sat_pos", lane(0), 131071);
        check_lanes("sat_pos");
        fill(-63488, 63488, 0);
        load_all();
        run(-1, -1, -1, 0, lat, nv, bok);
        check("sat_neg", lane(0), 131072);
        check_lanes("sat_neg");

        fill(0, 0, 0);
        for (int k = 0; k < O; k++) W[k][0] = 1;
        hv_int[0] = 1024;
        load_all();
        run(-1, -1, -1, 0, lat, nv, bok);
`ifdef DENSE_READOUT_ROUND_EN
        check("round_half_pos", lane(0), 1);
`else
        check("round_half_pos", lane(0), 0);
`endif
        check_lanes("round_pos");
        hv_int[0] = -1024;
        run(-1, -1, -1, 0, lat, nv, bok);
`ifdef DENSE_READOUT_ROUND_EN
        check("round_half_neg", lane(0), 0);
`else
        check("round_half_neg", lane(0), 18'h3FFFF);
`endif
        check_lanes("round_neg");

        fill(0, 1024, 2048);
        load_all();
        run(-1, -1, -1, 0, lat, nv, bok);
        check("bias_only", lane(0), 2048);
        check_lanes("bias_only");
        run(-1, -1, 4, 4, lat, nv, bok);
        check("rst_mid_npulse", nv, 0);
        check("rst_mid_outputVec", outputVec, 0);
        check("rst_mid_busy", busy, 0);
        run(-1, -1, -1, 0, lat, nv, bok);
        check("weights_survive", lane(0), 2048);

        for (int k = 0; k < O; k++) begin
            B[k] = int'($urandom_range(4095)) - 2048;
            for (int j = 0; j < H; j++) W[k][j] = int'($urandom_range(8191)) - 4096;
        end
        for (int j = 0; j < H; j++) hv_int[j] = int'($urandom_range(8191)) - 4096;
        load_all();
        run(3, 5, -1, 3, lat, nv, bok);
        check("overrun_latency", lat, 10);
        check("overrun_npulse", nv, 1);
        check("overrun_flag", overrun, 1);
        check_lanes("overrun_run");
        run(-1, -1, -1, 0, lat, nv, bok);
        check_lanes("mac_write_dropped");
        check("overrun_sticky", overrun, 1);

        for (int j = 0; j < H; j++) hv_int[j] = int'($urandom_range(8191)) - 4096;
        run(-1, -1, -1, 0, lat, nv, bok);
        check_lanes("b2b_first");
        for (int j = 0; j < H; j++) hv_int[j] = int'($urandom_range(8191)) - 4096;
        run(-1, -1, -1, 0, lat, nv, bok);
        check("b2b_latency", lat, 10);
        check_lanes("b2b_second");

        for (int k = 0; k < O; k++) d[k*BW +: BW] = BW'(int'($urandom_range(8191)) - 4096);
        hiddenVec = pack_h(); hiddenValid = 1'b1;
        wrEn = 1'b1; wrBias = 1'b0; wrAddr = '0; wrData = d;
        @(posedge clock); #1;
        hiddenValid = 1'b0; wrEn = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("simul_valid", outputValid, 1);
        check_lanes("simul_old_weight");
        for (int k = 0; k < O; k++) W[k][0] = int'($signed(d[k*BW +: BW]));
        run(-1, -1, -1, 0, lat, nv, bok);
        check_lanes("simul_new_weight");

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < O; k++) begin
                for (int j = 0; j < H; j++) begin
                    logic [BW-1:0] t;
                    t = BW'($urandom);
                    W[k][j] = (it < 3) ? int'($urandom_range(8191)) - 4096 : int'($signed(t));
                end
                B[k] = int'($urandom_range(16383)) - 8192;
            end
            for (int j = 0; j < H; j++) begin
                logic [BW-1:0] t;
                t = BW'($urandom);
                hv_int[j] = (it < 3) ? int'($urandom_range(16383)) - 8192 : int'($signed(t));
            end
            load_all();
            run(-1, -1, -1, 0, lat, nv, bok);
            check($sformatf("rand%0d_latency", it), lat, 10);
            check_lanes($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dense_readout.md
Name: dense_readout

Overview:
- Fully-connected linear readout stage directly downstream of the LSTM `network` block.
- Consumes the hidden-state vector (HIDDEN_SZ x Q6.11) when `network` asserts dataReady.
- Computes y = Wy·h + by for OUTPUT_SZ outputs: one MAC lane per output, sequenced serially over the hidden index.
- Presents a saturated Q6.11 output vector with a one-cycle valid pulse; weights and bias are loaded through a simple write port.

Parameters:
- HIDDEN_SZ, 8, number of hidden neurons consumed (power of 2, >=2).
- OUTPUT_SZ, 1, number of readout outputs (parallel MAC lanes).
- QN, 6, integer bits of the fixed-point format (sign excluded).
- QM, 11, fractional bits.
- BITWIDTH, QN+QM+1, word width (18).
- ADDR_BITWIDTH, clog2(HIDDEN_SZ), hidden-index/address width.
- ACC_BITWIDTH, 2*BITWIDTH+ADDR_BITWIDTH+1, accumulator width (no internal overflow).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- hiddenVec  in  BITWIDTH*HIDDEN_SZ  hidden vector; neuron j at [j*BITWIDTH +: BITWIDTH], signed Q6.11.
- hiddenValid  in  1  start strobe; driven by `network` dataReady.
- wrEn  in  1  weight/bias write strobe.
- wrBias  in  1  1: write bias vector; 0: write weight column.
- wrAddr  in  ADDR_BITWIDTH  hidden index j of the weight column.
- wrData  in  BITWIDTH*OUTPUT_SZ  lane k at [k*BITWIDTH +: BITWIDTH].
- outputVec  out  BITWIDTH*OUTPUT_SZ  result vector, signed Q6.11, lane k packed as wrData.
- outputValid  out  1  one-cycle pulse when outputVec updates.
- busy  out  1  high in LATCH, MAC and FINISH.
- overrun  out  1  sticky: hiddenValid arrived while busy.

Behaviour:
- Reset (async): state=IDLE; counter=0; accumulators=0; outputVec=0; outputValid=0; busy=0; overrun=0.
- Reset does not clear weights or bias (RAM semantics); they are loaded before reset deassertion and persist across resets.
- FSM states:
  - IDLE: on hiddenValid=1 (rising-edge sample, level-qualified), capture hiddenVec into an internal register; go to LATCH.
  - LATCH: clear all accumulators and counter; go to MAC.
  - MAC: per cycle, acc[k] += W[k][cnt] * h[cnt] (full 36-bit signed product, sign-extended to ACC_BITWIDTH). cnt increments; after cnt = HIDDEN_SZ-1, go to FINISH.
  - FINISH: s = acc[k] + (bias[k] <<< QM); r = s >>> QM (arithmetic, floor); saturate r to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]. Register r into outputVec lane k, pulse outputValid, go to IDLE.
- Latency: hiddenValid sampled at edge 0 → outputValid high after edge HIDDEN_SZ+2 (10 cycles at defaults).
- Back-to-back: a new hiddenValid is accepted in the cycle immediately after outputValid.
- Input capture: hiddenVec is captured once in IDLE; later changes do not affect the current computation.
- hiddenValid while busy: ignored; overrun set to 1 until reset.
- outputVec holds its last value until the next FINISH.
- Writes are honoured only in IDLE and dropped while busy.
  - wrBias=1: wrAddr is ignored and all OUTPUT_SZ biases are written.
  - wrBias=0: weight column wrAddr is written for all lanes.
- Simultaneous wrEn and hiddenValid in IDLE: the write lands, and the computation starts with the pre-write value of that word.
- Reset mid-MAC: computation is aborted and no outputValid pulse is produced.

Optional Feature:
- Macro: DENSE_READOUT_ROUND_EN.
- Defined: in FINISH, add 2^(QM-1) to s before the arithmetic shift (round half up).
- Undefined: plain floor truncation.
- Saturation applies after rounding in both cases.

Decomposition:
- Shared package `lstm_pkg`:
  - Q-format constants QN, QM, BITWIDTH.
  - Signed fixed-point typedef `fix_t`.
  - Saturation limit constants.
  - FSM state enum `readout_state_t`.
- One natural sub-module, `mac_lane`: per-output accumulator with clear/enable, FINISH round/saturate logic, instantiated OUTPUT_SZ times.
- Weight/bias storage and FSM stay in the top.

Test Plan:
- All weights 2048 (1.0), all h 1024 (0.5), bias 0, hiddenValid pulse → outputValid exactly 10 cycles later with outputVec=8192 (4.0); busy high for those cycles.
- Weights 63488 (31.0), h 31.0, bias 0 → outputVec=131071 (positive saturation). Negate all weights → 131072 in 18-bit two's complement (−2^17).
- W[0][0]=1, h0=1024, other h=0, bias 0 → output 0 without the macro, 1 with DENSE_READOUT_ROUND_EN. With h0=−1024: result −1 (all-ones) without the macro, 0 with it.
- Bias 2048, all weights 0 → outputVec=2048. Then reset mid-MAC (cycle 4) → no outputValid and outputVec=0. A new run without reloading weights still yields 2048 (weights survive reset).
- Second hiddenValid at cycle 3 of a run → ignored, overrun=1, single outputValid at cycle 10. wrEn during MAC does not alter stored weights.
- Two runs back-to-back, second hiddenValid the cycle after outputValid → second result correct, outputValid 10 cycles after the second start.
